dds_multichannel_core: RTL and testbench

DDS_MULTICHANNEL_CORE -- requirements
Module: dds_multichannel_core

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_channel.sv | 94 +++++++++
 rtl/dds_multichannel_core.sv | 135 +++++++++++++
 tb/tb_dds_multichannel_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants for the multichannel DDS: config register map and FSM encodings.
package dds_pkg;

    localparam logic [1:0] ADDR_M_BASE     = 2'd0;
    localparam logic [1:0] ADDR_OFFSET     = 2'd1;
    localparam logic [1:0] ADDR_SWEEP_STOP = 2'd2;
    localparam logic [1:0] ADDR_SWEEP_STEP = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } dds_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: phase accumulator, linear sweep of the tuning word and the
// per-tick capture of the offset-adjusted, truncated phase.
module dds_channel
    import dds_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic               i_sync,
    input  logic               i_we_base,
    input  logic               i_we_off,
    input  logic               i_we_stop,
    input  logic               i_we_step,
    input  logic [PHASE_W-1:0] i_data,
    input  logic               i_sweep_en,
    output logic [ADDR_W-1:0]  o_sample,
    output logic [ADDR_W-1:0]  o_held
);

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_m_base;
    logic [PHASE_W-1:0] r_m_cur;
    logic [PHASE_W-1:0] r_offset;
    logic [PHASE_W-1:0] r_stop;
    logic [PHASE_W-1:0] r_step;
    logic [ADDR_W-1:0]  r_held;

    logic [PHASE_W-1:0] w_acc_nxt;
    logic [PHASE_W-1:0] w_sum;
    logic [PHASE_W:0]   w_sweep;
    logic [PHASE_W-1:0] w_m_cur_nxt;

    // Accumulator next value; a sync coinciding with a tick restarts from M_cur
    always_comb begin
        w_acc_nxt = r_acc;
        if (i_sync) begin
            if (i_tick) begin
                w_acc_nxt = r_m_cur;
            end else begin
                w_acc_nxt = {PHASE_W{1'b0}};
            end
        end else if (i_tick) begin
            w_acc_nxt = r_acc + r_m_cur;
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    assign w_sum    = w_acc_nxt + r_offset;
    assign o_sample = w_sum[PHASE_W-1 -: ADDR_W];
    assign o_held   = r_held;
    assign w_sweep  = {1'b0, r_m_cur} + {1'b0, r_step};

    // Tuning word update: a base write always wins over the sweep step
    always_comb begin
        w_m_cur_nxt = r_m_cur;
        if (i_we_base) begin
            w_m_cur_nxt = i_data;
        end else if (i_tick && i_sweep_en) begin
            if (w_sweep > {1'b0, r_stop}) begin
                w_m_cur_nxt = r_m_base;
            end else begin
                w_m_cur_nxt = w_sweep[PHASE_W-1:0];
            end
        end else begin
            w_m_cur_nxt = r_m_cur;
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc    <= {PHASE_W{1'b0}};
            r_m_base <= {PHASE_W{1'b0}};
            r_m_cur  <= {PHASE_W{1'b0}};
            r_offset <= {PHASE_W{1'b0}};
            r_stop   <= {PHASE_W{1'b1}};
            r_step   <= {PHASE_W{1'b0}};
            r_held   <= {ADDR_W{1'b0}};
        end else begin
            r_acc   <= w_acc_nxt;
            r_m_cur <= w_m_cur_nxt;
            if (i_we_base) r_m_base <= i_data;
            if (i_we_off)  r_offset <= i_data;
            if (i_we_stop) r_stop   <= i_data;
            if (i_we_step) r_step   <= i_data;
            if (i_tick)    r_held   <= o_sample;
        end
    end

endmodule

// File: rtl/dds_multichannel_core.sv
// Multichannel DDS core: per-channel accumulators advanced by sample_tick, then a
// frame of one sample per channel streamed out under valid/ready handshake.
module dds_multichannel_core
    import dds_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 16,
    parameter int ADDR_W   = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_tick,
    input  logic                            phase_sync,
    input  logic                            cfg_we,
    input  logic [ch_width(CHANNELS)-1:0]   cfg_ch,
    input  logic [1:0]                      cfg_addr,
    input  logic [PHASE_W-1:0]              cfg_data,
    input  logic [CHANNELS-1:0]             sweep_en,
    input  logic                            overrun_clr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ch_width(CHANNELS)-1:0]   out_ch,
    output logic [ADDR_W-1:0]               out_phase,
    output logic                            overrun
);

    localparam int CH_W = ch_width(CHANNELS);

    dds_state_e        r_state;
    dds_state_e        w_state_nxt;
    logic [CH_W-1:0]   r_idx;
    logic [CH_W-1:0]   w_idx_nxt;
    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    logic [ADDR_W-1:0] r_out_phase;
    logic              r_overrun;

    logic              w_tick_acc;
    logic              w_tick_drop;
    logic              w_hs;
    logic              w_last;
    logic [ADDR_W-1:0] w_sample [CHANNELS];
    logic [ADDR_W-1:0] w_held   [CHANNELS];

    assign w_tick_acc  = sample_tick && (r_state == ST_IDLE);
    assign w_tick_drop = sample_tick && (r_state == ST_EMIT);
    assign w_hs        = r_out_valid && out_ready;
    assign w_last      = (r_idx == CH_W'(CHANNELS - 1));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic w_we;
        assign w_we = cfg_we && (cfg_ch == CH_W'(g));

        dds_channel #(
            .PHASE_W (PHASE_W),
            .ADDR_W  (ADDR_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_tick     (w_tick_acc),
            .i_sync     (phase_sync),
            .i_we_base  (w_we && (cfg_addr == ADDR_M_BASE)),
            .i_we_off   (w_we && (cfg_addr == ADDR_OFFSET)),
            .i_we_stop  (w_we && (cfg_addr == ADDR_SWEEP_STOP)),
            .i_we_step  (w_we && (cfg_addr == ADDR_SWEEP_STEP)),
            .i_data     (cfg_data),
            .i_sweep_en (sweep_en[g]),
            .o_sample   (w_sample[g]),
            .o_held     (w_held[g])
        );
    end

    // Frame sequencing: next state and channel index
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_tick_acc) begin
                    w_state_nxt = ST_EMIT;
                    w_idx_nxt   = {CH_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (w_hs && w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = {CH_W{1'b0}};
                end else if (w_hs) begin
                    w_idx_nxt = r_idx + CH_W'(1);
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = {CH_W{1'b0}};
            end
        endcase
    end

    // FSM state plus registered outputs; out_phase only moves on tick or handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= {CH_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_ch    <= {CH_W{1'b0}};
            r_out_phase <= {ADDR_W{1'b0}};
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= (w_state_nxt == ST_EMIT);
            r_out_ch    <= w_idx_nxt;
            if (w_tick_acc) begin
                r_out_phase <= w_sample[0];
            end else if (w_hs && !w_last) begin
                r_out_phase <= w_held[w_idx_nxt];
            end
            if (w_tick_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_phase = r_out_phase;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_dds_multichannel_core.sv
// Directed bench for dds_multichannel_core with a reference model feeding a scoreboard queue.
module tb_dds_multichannel_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        phase_sync;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [1:0]  sweep_en;
    logic        overrun_clr;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [9:0]  out_phase;
    logic        overrun;

    always #5 clk = ~clk;

    dds_multichannel_core #(.CHANNELS(2), .PHASE_W(16), .ADDR_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .phase_sync  (phase_sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .sweep_en    (sweep_en),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_phase   (out_phase),
        .overrun     (overrun)
    );

    typedef struct {
        logic [0:0] ch;
        logic [9:0] ph;
    } exp_t;

    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          m_rem    = 0;
    logic        m_ovr    = 1'b0;
    logic [15:0] m_acc  [2];
    logic [15:0] m_cur  [2];
    logic [15:0] m_base [2];
    logic [15:0] m_off  [2];
    logic [15:0] m_stop [2];
    logic [15:0] m_step [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from the inputs currently driven, check, then clear pulses.
    task automatic cyc();
        bit          busy;
        bit          acc_t;
        logic [15:0] a;
        logic [15:0] s;
        logic [16:0] nxt;
        exp_t        e;
        busy  = (m_rem != 0);
        acc_t = sample_tick && !busy;
        if (rst && out_valid && sb_q.size() > 0) begin
            e = sb_q[0];
            chk(out_ready ? "hs_ch" : "stall_ch", out_ch, e.ch);
            chk(out_ready ? "hs_phase" : "stall_phase", out_phase, e.ph);
            if (out_ready) begin
                void'(sb_q.pop_front());
                if (m_rem > 0) m_rem--;
            end
        end
        if (!rst) begin
            sb_q.delete();
            m_rem = 0;
            m_ovr = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 16'h0; m_cur[i] = 16'h0; m_base[i] = 16'h0;
                m_off[i] = 16'h0; m_stop[i] = 16'hFFFF; m_step[i] = 16'h0;
            end
        end else begin
            if (sample_tick && busy) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (acc_t) begin
                    a = phase_sync ? m_cur[i] : (m_acc[i] + m_cur[i]);
                    s = a + m_off[i];
                    e.ch = i[0:0];
                    e.ph = s[15:6];
                    sb_q.push_back(e);
                    if (sweep_en[i]) begin
                        nxt = {1'b0, m_cur[i]} + {1'b0, m_step[i]};
                        m_cur[i] = (nxt > {1'b0, m_stop[i]}) ? m_base[i] : nxt[15:0];
                    end
                    m_acc[i] = a;
                end else if (phase_sync) begin
                    m_acc[i] = 16'h0;
                end
                if (cfg_we && cfg_ch == i[0:0]) begin
                    case (cfg_addr)
                        2'd0: begin m_base[i] = cfg_data; m_cur[i] = cfg_data; end
                        2'd1: m_off[i]  = cfg_data;
                        2'd2: m_stop[i] = cfg_data;
                        default: m_step[i] = cfg_data;
                    endcase
                end
            end
            if (acc_t) m_rem = 2;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, (m_rem != 0));
        chk("overrun", overrun, m_ovr);
        rst = 1'b1; sample_tick = 1'b0; phase_sync = 1'b0; cfg_we = 1'b0; overrun_clr = 1'b0;
    endtask

    task automatic wr(input logic [0:0] ch, input logic [1:0] addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
        cyc();
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && m_rem != 0; k++) cyc();
        chk("drain_timeout", (m_rem == 0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        logic [15:0] cum [5];
        cum = '{16'h0010, 16'h0030, 16'h0060, 16'h0070, 16'h0090};
        rst = 1'b0; sample_tick = 1'b0; phase_sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0; sweep_en = 2'b00;
        overrun_clr = 1'b0; out_ready = 1'b1;
        do_reset();
        do_reset();
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_phase", out_phase, 0);
        chk("rst_stop", dut.g_ch[0].u_ch.r_stop, 16'hFFFF);

        // Frequency: 4 frames of ch0 then ch1
        wr(1'b0, 2'd0, 16'h0100);
        wr(1'b1, 2'd0, 16'h0400);
        for (int t = 0; t < 4; t++) begin
            tick();
            drain();
        end

        // Offset and wrap
        do_reset();
        wr(1'b1, 2'd0, 16'h0000);
        wr(1'b1, 2'd1, 16'h4000);
        wr(1'b0, 2'd0, 16'h8000);
        for (int t = 0; t < 4; t++) begin
            tick();
            drain();
        end

        // Sweep on ch0
        do_reset();
        wr(1'b0, 2'd0, 16'h0010);
        wr(1'b0, 2'd3, 16'h0010);
        wr(1'b0, 2'd2, 16'h0030);
        sweep_en = 2'b01;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("sweep_acc", dut.g_ch[0].u_ch.r_acc, cum[t]);
            drain();
        end
        sweep_en = 2'b00;

        // Backpressure, dropped tick, offset change while stalled
        do_reset();
        wr(1'b0, 2'd0, 16'h0100);
        wr(1'b1, 2'd0, 16'h0400);
        out_ready = 1'b0;
        tick();
        cyc();
        sample_tick = 1'b1; cyc();
        wr(1'b0, 2'd1, 16'h1000);
        cyc();
        cyc();
        chk("bp_acc0", dut.g_ch[0].u_ch.r_acc, 16'h0100);
        chk("bp_acc1", dut.g_ch[1].u_ch.r_acc, 16'h0400);
        chk("bp_overrun", overrun, 1);
        sample_tick = 1'b1; overrun_clr = 1'b1; cyc();
        out_ready = 1'b1;
        drain();
        overrun_clr = 1'b1; cyc();
        chk("ovr_cleared", overrun, 0);
        tick();
        drain();

        // Reset in the middle of a frame
        out_ready = 1'b0;
        tick();
        chk("mid_valid", out_valid, 1);
        do_reset();
        chk("mid_rst_ch", out_ch, 0);
        chk("mid_rst_phase", out_phase, 0);
        chk("mid_rst_acc0", dut.g_ch[0].u_ch.r_acc, 16'h0);
        chk("mid_rst_mcur1", dut.g_ch[1].u_ch.r_m_cur, 16'h0);
        chk("mid_rst_off0", dut.g_ch[0].u_ch.r_offset, 16'h0);
        out_ready = 1'b1;
        cyc();

        // Tick + phase_sync + M_BASE write in the same cycle
        wr(1'b0, 2'd0, 16'h0100);
        tick();
        drain();
        tick();
        drain();
        sample_tick = 1'b1; phase_sync = 1'b1;
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0300;
        cyc();
        chk("coin_acc0", dut.g_ch[0].u_ch.r_acc, 16'h0100);
        chk("coin_mcur0", dut.g_ch[0].u_ch.r_m_cur, 16'h0300);
        drain();
        tick();
        drain();
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
